topk_tracker: RTL

- Streaming top-K tracker for unsigned (optionally signed) samples; generalises the second-largest finder to any rank depth K.
- Holds a sorted table of the K largest values seen since reset or the last window clear.
- Presents the K-th largest on dout, plus random read access to any rank.
- Sits after sample-capture logic in stats/monitor paths; one sample accepted per cycle, no backpressure.

---
 rtl/topk_pkg.sv | 21 ++
 rtl/topk_tracker_if.sv | 31 +++
 rtl/topk_slot.sv | 30 +++
 rtl/topk_tracker.sv | 123 ++++++++++++
 4 files changed

// File: rtl/topk_pkg.sv
// Shared types and helpers for the top-K tracker.
// TOPK_SLOT_T(W) builds the {occ, val} slot record for a given sample width.
`ifndef TOPK_SLOT_T
`define TOPK_SLOT_T(W) struct packed { logic occ; logic [(W)-1:0] val; }
`endif

package topk_pkg;
  localparam int TOPK_MAX_K = 16;
  localparam int TOPK_MAX_W = 64;

  typedef enum logic [1:0] {SEL_KEEP, SEL_INS, SEL_SHF, SEL_CLR} sel_e;

  // Operands arrive MSB-aligned in TOPK_MAX_W bits, so one comparator serves
  // every sample width in either signedness.
  function automatic logic topk_gt(input logic [TOPK_MAX_W-1:0] a,
                                   input logic [TOPK_MAX_W-1:0] b,
                                   input logic signed_mode);
    if (signed_mode) return $signed(a) > $signed(b);
    return a > b;
  endfunction
endpackage

// File: rtl/topk_tracker_if.sv
// Sample/readback bundle for topk_tracker; dup_hit exists only with TOPK_DEDUP_EN.
interface topk_tracker_if #(
  parameter int DATA_WIDTH = 32,
  parameter int K          = 4,
  parameter int CNT_WIDTH  = 16
);
  localparam int IDX_W = $clog2(K);

  logic                  din_valid;
  logic [DATA_WIDTH-1:0] din;
  logic                  clear;
  logic [IDX_W-1:0]      rd_idx;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_hit;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dout_valid;
  logic [CNT_WIDTH-1:0]  sample_cnt;

`ifdef TOPK_DEDUP_EN
  logic                  dup_hit;
  modport master (output din_valid, din, clear, rd_idx,
                  input  rd_data, rd_hit, dout, dout_valid, sample_cnt, dup_hit);
  modport slave  (input  din_valid, din, clear, rd_idx,
                  output rd_data, rd_hit, dout, dout_valid, sample_cnt, dup_hit);
`else
  modport master (output din_valid, din, clear, rd_idx,
                  input  rd_data, rd_hit, dout, dout_valid, sample_cnt);
  modport slave  (input  din_valid, din, clear, rd_idx,
                  output rd_data, rd_hit, dout, dout_valid, sample_cnt);
`endif
endinterface

// File: rtl/topk_slot.sv
// One rank cell: keeps, takes din, takes the upper neighbour, or empties.
module topk_slot
  import topk_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  sel_e                  sel,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic [DATA_WIDTH-1:0] up_val,
  input  logic                  up_occ,
  output logic                  occ,
  output logic [DATA_WIDTH-1:0] val
);
  // Empty cells always hold zero, so a shifted-down empty slot stays clean.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      occ <= 1'b0;
      val <= '0;
    end else begin
      unique case (sel)
        SEL_INS: begin occ <= 1'b1;   val <= din;    end
        SEL_SHF: begin occ <= up_occ; val <= up_val; end
        SEL_CLR: begin occ <= 1'b0;   val <= '0;     end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/topk_tracker.sv
// Streaming top-K tracker: sorted table of the K largest samples, rank readback.
// Define TOPK_DEDUP_EN to reject samples already present and expose dup_hit.
module topk_tracker
  import topk_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int K          = 4,
  parameter int CNT_WIDTH  = 16,
  parameter int SIGNED     = 0
) (
  input logic           clk,
  input logic           resetn,
  topk_tracker_if.slave bus
);
  localparam int IDX_W = $clog2(K);
`ifdef TOPK_DEDUP_EN
  localparam bit DEDUP = 1'b1;
`else
  localparam bit DEDUP = 1'b0;
`endif

  typedef `TOPK_SLOT_T(DATA_WIDTH) slot_t;

  slot_t [K-1:0]         tbl;
  logic  [K-1:0]         gt;
  logic  [K-1:0]         gt_up;
  logic                  dup;
  logic                  ins_ok;
  sel_e  [K-1:0]         sel;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_hit_q;

  function automatic logic [TOPK_MAX_W-1:0] align(input logic [DATA_WIDTH-1:0] v);
    return TOPK_MAX_W'(v) << (TOPK_MAX_W - DATA_WIDTH);
  endfunction

  // gt is a thermometer code (0s over larger/equal entries, then 1s), because
  // the table is sorted and occupancy is contiguous; its first 1 is the insert slot.
  always_comb begin
    dup = 1'b0;
    gt  = '0;
    for (int i = 0; i < K; i++) begin
      gt[i] = !tbl[i].occ || topk_gt(align(bus.din), align(tbl[i].val), SIGNED != 0);
      if (tbl[i].occ && tbl[i].val == bus.din) dup = 1'b1;
    end
  end

  assign gt_up  = {gt[K-2:0], 1'b0};
  assign ins_ok = bus.din_valid && !(DEDUP && dup);

  always_comb begin
    sel = '0;
    for (int i = 0; i < K; i++) begin
      sel[i] = SEL_KEEP;
      if (bus.clear)
        sel[i] = (i == 0 && bus.din_valid) ? SEL_INS : SEL_CLR;
      else if (ins_ok) begin
        if (gt_up[i])   sel[i] = SEL_SHF;
        else if (gt[i]) sel[i] = SEL_INS;
      end
    end
  end

  for (genvar g = 0; g < K; g++) begin : g_slot
    logic [DATA_WIDTH-1:0] up_val;
    logic                  up_occ;
    if (g == 0) begin : g_top
      assign up_val = '0;
      assign up_occ = 1'b0;
    end else begin : g_mid
      assign up_val = tbl[g-1].val;
      assign up_occ = tbl[g-1].occ;
    end
    topk_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot (
      .clk    (clk),
      .resetn (resetn),
      .sel    (sel[g]),
      .din    (bus.din),
      .up_val (up_val),
      .up_occ (up_occ),
      .occ    (tbl[g].occ),
      .val    (tbl[g].val)
    );
  end

  // Readback samples the table as it stood before this edge's update.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q     <= '0;
      rd_data_q <= '0;
      rd_hit_q  <= 1'b0;
    end else begin
      if (bus.clear)
        cnt_q <= CNT_WIDTH'(bus.din_valid);
      else if (bus.din_valid && cnt_q != '1)
        cnt_q <= cnt_q + 1'b1;
      rd_data_q <= '0;
      rd_hit_q  <= 1'b0;
      for (int i = 0; i < K; i++) begin
        if (bus.rd_idx == IDX_W'(i) && tbl[i].occ) begin
          rd_data_q <= tbl[i].val;
          rd_hit_q  <= 1'b1;
        end
      end
    end
  end

`ifdef TOPK_DEDUP_EN
  logic dup_q;
  always_ff @(posedge clk) begin
    if (!resetn) dup_q <= 1'b0;
    else         dup_q <= bus.din_valid && !bus.clear && dup;
  end
  assign bus.dup_hit = dup_q;
`endif

  assign bus.rd_data    = rd_data_q;
  assign bus.rd_hit     = rd_hit_q;
  assign bus.sample_cnt = cnt_q;
  assign bus.dout       = tbl[K-1].occ ? tbl[K-1].val : '0;
  assign bus.dout_valid = tbl[K-1].occ;
endmodule
